// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: fixed-latency tag pipeline plus per-register
// outstanding counters for variable-latency writers. Optional macro: HAZARD_SCOREBOARD_FWD_EN.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int DEPTH    = 3,
  parameter int CNT_W    = 2
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                pipe_advance,
  input  logic                issue_valid,
  input  logic [REG_W-1:0]    issue_rs,
  input  logic                issue_rs_use,
  input  logic [REG_W-1:0]    issue_rt,
  input  logic                issue_rt_use,
  input  logic [REG_W-1:0]    issue_rd,
  input  logic                issue_regwrite,
  input  logic                issue_long,
  input  logic                issue_abuf,
  input  logic                all_buf_flags,
  input  logic                flush,
  input  logic                long_done,
  input  logic [REG_W-1:0]    long_done_rd,
  output logic                stall,
  output logic                issue_accept,
  output logic [NUM_REGS-1:0] busy,
  output logic                err_underflow
);

  localparam int SUM_W = CNT_W + $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DEPTH-1:0] tag_valid_q, tag_valid_d;
  logic [DEPTH-1:0] tag_long_q,  tag_long_d;
  logic [REG_W-1:0] tag_rd_q [DEPTH];
  logic [REG_W-1:0] tag_rd_d [DEPTH];
  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic             err_q, err_d;

  logic             haz_rs_s, haz_rt_s, ovf_guard_s;
  logic [SUM_W-1:0] long_sum_s;
  logic [DEPTH-1:0] valid_src_s;
  logic             load_s, exit_long_s;
  logic [REG_W-1:0] exit_rd_s;

  // Source hazards and the outstanding-long overflow guard for the decode instruction
  always_comb begin
    haz_rs_s   = 1'b0;
    haz_rt_s   = 1'b0;
    long_sum_s = SUM_W'(cnt_q[issue_rd]);
    for (int k = 0; k < DEPTH; k++) begin
      logic fwd_skip;
      fwd_skip = 1'b0;
`ifdef HAZARD_SCOREBOARD_FWD_EN
      // The oldest fixed-latency result is forwarded, so it never blocks a reader.
      fwd_skip = (k == DEPTH - 1) && !tag_long_q[k];
`endif
      if (tag_valid_q[k] && !fwd_skip) begin
        if (tag_rd_q[k] == issue_rs) haz_rs_s = 1'b1;
        else                         haz_rs_s = haz_rs_s;
        if (tag_rd_q[k] == issue_rt) haz_rt_s = 1'b1;
        else                         haz_rt_s = haz_rt_s;
      end else begin
        haz_rs_s = haz_rs_s;
      end
      if (tag_valid_q[k] && tag_long_q[k] && (tag_rd_q[k] == issue_rd)) begin
        long_sum_s = long_sum_s + SUM_W'(1);
      end else begin
        long_sum_s = long_sum_s;
      end
    end
    if (cnt_q[issue_rs] != '0) haz_rs_s = 1'b1;
    else                       haz_rs_s = haz_rs_s;
    if (cnt_q[issue_rt] != '0) haz_rt_s = 1'b1;
    else                       haz_rt_s = haz_rt_s;
    if (issue_rs == '0) haz_rs_s = 1'b0;
    else                haz_rs_s = haz_rs_s;
    if (issue_rt == '0) haz_rt_s = 1'b0;
    else                haz_rt_s = haz_rt_s;
    ovf_guard_s = issue_long && issue_regwrite && (issue_rd != '0) &&
                  (long_sum_s >= SUM_W'(CNT_MAX));
  end

  assign stall = issue_valid && ((issue_rs_use && haz_rs_s) ||
                                 (issue_rt_use && haz_rt_s) ||
                                 (issue_abuf && !all_buf_flags) ||
                                 ovf_guard_s);
  assign issue_accept = issue_valid && pipe_advance && !stall;

  // Tag pipeline next state; a flushed stage-0 entry is dropped before it can shift
  always_comb begin
    valid_src_s    = tag_valid_q;
    valid_src_s[0] = tag_valid_q[0] && !flush;
    load_s         = issue_accept && issue_regwrite && (issue_rd != '0);
    tag_valid_d    = valid_src_s;
    tag_long_d     = tag_long_q;
    for (int k = 0; k < DEPTH; k++) tag_rd_d[k] = tag_rd_q[k];
    exit_long_s = pipe_advance && valid_src_s[DEPTH-1] && tag_long_q[DEPTH-1];
    exit_rd_s   = tag_rd_q[DEPTH-1];
    if (pipe_advance) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        tag_valid_d[k] = valid_src_s[k-1];
        tag_long_d[k]  = tag_long_q[k-1];
        tag_rd_d[k]    = tag_rd_q[k-1];
      end
      tag_valid_d[0] = load_s;
      tag_long_d[0]  = load_s && issue_long;
      tag_rd_d[0]    = load_s ? issue_rd : '0;
    end else begin
      tag_valid_d = valid_src_s;
    end
  end

  // Outstanding counters; a simultaneous exit and retire on one register cancel out
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      logic inc, dec;
      inc      = exit_long_s && (exit_rd_s == REG_W'(r));
      dec      = long_done && (long_done_rd == REG_W'(r)) && (r != 0);
      cnt_d[r] = cnt_q[r];
      if (inc && !dec) begin
        if (cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + CNT_W'(1);
        else                     cnt_d[r] = cnt_q[r];
      end else if (dec && !inc) begin
        if (cnt_q[r] == '0) err_d    = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  // Per-register pending view: any in-flight tag or a nonzero counter
  always_comb begin
    busy = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy[r] = (cnt_q[r] != '0);
      for (int k = 0; k < DEPTH; k++) begin
        if (tag_valid_q[k] && (tag_rd_q[k] == REG_W'(r))) busy[r] = 1'b1;
        else                                               busy[r] = busy[r];
      end
    end
  end

  assign err_underflow = err_q;

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      tag_valid_q <= '0;
      tag_long_q  <= '0;
      for (int k = 0; k < DEPTH; k++) tag_rd_q[k] <= '0;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      tag_valid_q <= tag_valid_d;
      tag_long_q  <= tag_long_d;
      for (int k = 0; k < DEPTH; k++) tag_rd_q[k] <= tag_rd_d[k];
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the decode-stage hazard comparator.
- Replaces the fixed three-stage rs/rt destination comparators with two trackers:
  - a DEPTH-stage shift pipeline of in-flight destination tags;
  - per-register outstanding counters for variable-latency (SAD/buffer) writers.
- Sits beside the decode stage and drives the decode stall.
- Also absorbs the all-buffer wait condition.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is never tracked.
- REG_W, 5, register index width; must equal clog2(NUM_REGS).
- DEPTH, 3, fixed-latency stages between decode and writeback; minimum 1.
- CNT_W, 2, width of each outstanding counter; max outstanding = 2^CNT_W-1.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous active-high reset.
- pipe_advance  in  1  global pipeline enable; tags shift and issue is accepted only when high.
- issue_valid  in  1  decode holds a valid instruction.
- issue_rs  in  REG_W  source register 1.
- issue_rs_use  in  1  instruction reads rs.
- issue_rt  in  REG_W  source register 2.
- issue_rt_use  in  1  instruction reads rt.
- issue_rd  in  REG_W  destination register.
- issue_regwrite  in  1  instruction writes rd.
- issue_long  in  1  writer completes with variable latency (signalled via long_done).
- issue_abuf  in  1  instruction is the all-buffer wait op.
- all_buf_flags  in  1  all SAD buffers loaded.
- flush  in  1  squash the youngest tag (stage 0) this cycle.
- long_done  in  1  a variable-latency write retires this cycle.
- long_done_rd  in  REG_W  register retired by long_done.
- stall  out  1  hold decode; combinational.
- issue_accept  out  1  issue_valid & pipe_advance & ~stall.
- busy  out  NUM_REGS  per-register pending (any tag match or counter nonzero).
- err_underflow  out  1  sticky; long_done on a register whose counter is 0.

Behaviour:
- Reset: all tags invalid, all counters 0, err_underflow 0.
  - Outputs after reset: stall = issue_valid & issue_abuf & ~all_buf_flags; busy all 0; issue_accept follows inputs.
- Tag entry: {valid, rd, long}, stages 0..DEPTH-1.
  - On pipe_advance, stage k moves to stage k+1.
  - Stage 0 loads a valid entry iff issue_accept & issue_regwrite & rd!=0; otherwise it loads a bubble.
  - pipe_advance low: tags hold and nothing is accepted.
- Exit: on pipe_advance, a valid stage DEPTH-1 entry retires.
  - If its long bit is set, counter[rd] increments.
  - Otherwise the write is complete.
- Retire: long_done decrements counter[long_done_rd], regardless of pipe_advance.
  - long_done_rd==0 is ignored.
  - Counter at 0: counter stays 0 and err_underflow is set.
- Simultaneous increment and decrement on the same register: counter is unchanged and no error is raised.
- Flush: stage 0 entry is invalidated before the shift. With flush and pipe_advance in the same cycle, the squashed entry does not reach stage 1.
  - Flush has priority over the new issue's effect on other stages only; the new issue still loads into stage 0 if accepted.
  - Accepted issue and flush in the same cycle: the new entry is kept and the old stage-0 entry is dropped.
- Hazard on r (r != 0): any valid tag with rd==r, or counter[r] != 0.
- stall is asserted (same cycle, combinational) if any of:
  - issue_valid & issue_rs_use & hazard(issue_rs);
  - issue_valid & issue_rt_use & hazard(issue_rt);
  - issue_valid & issue_abuf & ~all_buf_flags;
  - issue_valid & issue_long & issue_regwrite & rd!=0 & (counter[rd] + long tags for rd in pipe) == 2^CNT_W-1 (overflow guard).
- Registered state changes take effect the cycle after the triggering edge.
- Rst mid-operation clears everything regardless of other inputs.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_FWD_EN.
- Defined: a valid non-long tag in stage DEPTH-1 does not count toward the rs/rt hazard, because it is bypassed by forwarding. busy still reports it.
- Undefined: every valid tag causes a hazard.

Test Plan:
- Reset, issue add rd=5; next cycle issue rs=5 with rs_use -> stall=1 for DEPTH cycles, then 0. With FWD_EN, stall=1 for DEPTH-1 cycles.
- Issue long rd=7; after DEPTH advances counter[7]=1 and busy[7]=1. An rt=7 reader stalls until long_done with rd=7, then stall=0 the next cycle.
- Issue 3 long writes to rd=9 with CNT_W=2 -> the 4th long issue to rd=9 gets stall=1. long_done rd=9 the same cycle as a long exit -> counter stays 3.
- Issue rd=4, then flush in the next cycle with pipe_advance -> busy[4]=0 immediately after. A reader of r4 is not stalled.
- long_done rd=12 with counter 0 -> err_underflow=1 sticky, clearing only on Rst. Issue abuf with all_buf_flags=0 -> stall=1; flags=1 -> stall=0.
- pipe_advance=0 for 5 cycles with a tag for rd=3 in stage 1 -> busy[3] stays 1 and the tag stays put. Rst asserted -> busy=0 next cycle.
